cr_huf_comp_sq_pf: RTL and testbench
====================================

CR_HUF_COMP_SQ_PF -- requirements
Module: cr_huf_comp_sq_pf

Interface
REQ-001 SHALL have parameter DEPTH, default 16: symbol entries held (storage plus output register), power of two, at least 4.
REQ-002 SHALL have parameter DATA_W, default 64: symbol data width.
REQ-003 SHALL have parameter SEQ_W, default 4: seq_id width.
REQ-004 SHALL have parameter AF_MARGIN, default 2: free slots reserved for upstream pipeline slip, below DEPTH-1.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; ports named clk and rst_n as in the codebase (active-high despite the suffix).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous reset, active-high.
REQ-008 clear  in  1  synchronous flush of queue contents and high-water mark.
REQ-009 wr  in  1  write strobe from symbol map.
REQ-010 wr_sym  in  s_sq_sym  {eot, sot, byte_vld[3], tlast, eob, seq_id[SEQ_W], data[DATA_W]}.
REQ-011 rdy  out  1  upstream may issue wr next cycle.
REQ-012 rd  in  1  pop the head entry (symbol assembler).
REQ-013 out_vld  out  1  out_sym holds a valid head entry.
REQ-014 out_sym  out  s_sq_sym  head entry, registered.
REQ-015 used_slots  out  clog2(DEPTH+1)  current occupancy.
REQ-016 aempty  out  1  used_slots equals 1.
REQ-017 hwm  out  clog2(DEPTH+1)  highest used_slots since reset or clear.
REQ-018 overflow  out  1  sticky: a write was dropped.
REQ-019 underflow  out  1  sticky: rd was issued while out_vld was 0.

Function
REQ-020 SHALL be a show-ahead FIFO: storage array plus one output register; out_sym is always driven from flops.
REQ-021 First write into an empty queue: out_vld SHALL be 1 on the cycle after wr; no rd needed.
REQ-022 rd with out_vld=1 SHALL advance the head; the next entry SHALL be present on the following cycle with no bubble.
REQ-023 wr and rd on the same cycle with used_slots=1 SHALL pass the new entry to the output register; out_vld stays 1 and used_slots stays 1.
REQ-024 used_slots SHALL increment on an accepted write without a pop, decrement on a pop without a write, and hold otherwise.
REQ-025 rdy SHALL be 1 exactly when used_slots < DEPTH-AF_MARGIN, combinational from the used_slots register.
REQ-026 wr with used_slots=DEPTH and no rd on the same cycle SHALL be dropped, set overflow, and leave state unchanged.
REQ-027 wr with used_slots=DEPTH and rd on the same cycle SHALL be accepted.
REQ-028 rd with out_vld=0 SHALL be ignored and SHALL set underflow.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH-1 storage slots with no lost or duplicated entry.
REQ-030 hwm SHALL update to used_slots whenever used_slots exceeds it.
REQ-031 clear SHALL take priority over wr and rd on the same cycle; the next cycle has used_slots=0, out_vld=0 and hwm=0.
REQ-032 clear SHALL NOT reset overflow or underflow.
REQ-033 Field order in out_sym SHALL equal field order in wr_sym, bit for bit.

Reset
REQ-034 Asserting rst_n SHALL immediately force all of these to zero: pointers, used_slots, out_vld, out_sym, hwm, overflow, underflow.
REQ-035 After reset, rdy SHALL be 1 and aempty SHALL be 0.
REQ-036 Reset asserted mid-burst SHALL discard all contents; the first post-reset write behaves as REQ-021.
REQ-037 The storage array itself SHALL NOT require reset.

Structure
REQ-038 s_sq_sym, the depth and width defaults and the AF_MARGIN default SHALL live in cr_huf_compPKG.
REQ-039 Storage SHALL be one sub-module, cr_huf_comp_sq_pf_ram: a DEPTH-1 by s_sq_sym register array with a one-write and one-read port and a combinational read.

Verification
REQ-040 Write A, B, C on consecutive cycles with no rd -> out_vld=1 with A on cycle 1; used_slots reads 1, 2, 3; hwm=3.
REQ-041 Fill with 16 writes (DEPTH=16, AF_MARGIN=2) -> rdy=0 from used_slots=14; a 17th wr sets overflow; contents read back 0..15 in order.
REQ-042 used_slots=1 with wr and rd together -> new entry on out_sym next cycle; out_vld stays 1; aempty stays 1.
REQ-043 rd with the queue empty -> underflow=1; used_slots stays 0; out_vld stays 0.
REQ-044 used_slots=5, then clear together with wr -> used_slots=0, hwm=0, out_vld=0; overflow and underflow unchanged.
REQ-045 Reset after 40 random writes and reads -> all outputs 0; writing X then returns X as the first entry (exercises pointer wrap).

Source files
------------

// File: rtl/cr_huf_comp_pkg.sv
// rtl/cr_huf_comp_pkg.sv - shared symbol-queue types and defaults
package cr_huf_compPKG;

    localparam int SQ_DEPTH     = 16;
    localparam int SQ_DATA_W    = 64;
    localparam int SQ_SEQ_W     = 4;
    localparam int SQ_AF_MARGIN = 2;

    typedef struct packed {
        logic                 eot;
        logic                 sot;
        logic [2:0]           byte_vld;
        logic                 tlast;
        logic                 eob;
        logic [SQ_SEQ_W-1:0]  seq_id;
        logic [SQ_DATA_W-1:0] data;
    } s_sq_sym;

endpackage

// File: rtl/cr_huf_comp_sq_pf_ram.sv
// rtl/cr_huf_comp_sq_pf_ram.sv - symbol queue storage, one write port, combinational read
module cr_huf_comp_sq_pf_ram
    import cr_huf_compPKG::*;
#(
    parameter  int DEPTH = SQ_DEPTH,
    localparam int PW    = $clog2(DEPTH - 1)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  s_sq_sym       wdata,
    input  logic [PW-1:0] raddr,
    output s_sq_sym       rdata
);

    s_sq_sym mem_q [DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cr_huf_comp_sq_pf.sv
// rtl/cr_huf_comp_sq_pf.sv - show-ahead symbol queue: storage array plus registered head
module cr_huf_comp_sq_pf
    import cr_huf_compPKG::*;
#(
    parameter  int DEPTH     = SQ_DEPTH,
    parameter  int DATA_W    = SQ_DATA_W,
    parameter  int SEQ_W     = SQ_SEQ_W,
    parameter  int AF_MARGIN = SQ_AF_MARGIN,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr,
    input  s_sq_sym       wr_sym,
    output logic          rdy,
    input  logic          rd,
    output logic          out_vld,
    output s_sq_sym       out_sym,
    output logic [CW-1:0] used_slots,
    output logic          aempty,
    output logic [CW-1:0] hwm,
    output logic          overflow,
    output logic          underflow
);

    localparam int            PW       = $clog2(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 2);

    // The symbol layout is fixed by the package; width parameters must agree with it.
    if ($bits(s_sq_sym) != DATA_W + SEQ_W + 7) begin : g_sym_width_mismatch
        localparam int SYM_W_DELTA = $bits(s_sq_sym) - (DATA_W + SEQ_W + 7);
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] used_q, used_d, hwm_q, hwm_d, mem_cnt;
    logic          out_vld_q, out_vld_d, ovf_q, ovf_d, udf_q, udf_d;
    logic          pop, push, load, mem_we;
    s_sq_sym       out_sym_q, out_sym_d, ram_rdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    cr_huf_comp_sq_pf_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (wr_sym),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        used_d    = used_q;
        hwm_d     = hwm_q;
        out_vld_d = out_vld_q;
        out_sym_d = out_sym_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        mem_we    = 1'b0;
        pop       = rd & out_vld_q;
        push      = wr & ((used_q != CW'(DEPTH)) | pop);
        mem_cnt   = used_q - CW'(out_vld_q);
        load      = pop | ~out_vld_q;
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            used_d    = '0;
            hwm_d     = '0;
            out_vld_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (wr & ~push);
            udf_d = udf_q | (rd & ~out_vld_q);
            // Head refills from storage first; a write bypasses only when storage is empty.
            if (load && mem_cnt != '0) begin
                out_sym_d = ram_rdata;
                out_vld_d = 1'b1;
                rd_ptr_d  = ptr_inc(rd_ptr_q);
            end else if (load && push) begin
                out_sym_d = wr_sym;
                out_vld_d = 1'b1;
            end else if (pop) begin
                out_vld_d = 1'b0;
            end
            mem_we = push & ~(load & (mem_cnt == '0));
            if (mem_we) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   used_d = used_q + 1'b1;
                2'b01:   used_d = used_q - 1'b1;
                default: used_d = used_q;
            endcase
            if (used_d > hwm_q) begin
                hwm_d = used_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            used_q    <= '0;
            hwm_q     <= '0;
            out_vld_q <= 1'b0;
            out_sym_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            used_q    <= used_d;
            hwm_q     <= hwm_d;
            out_vld_q <= out_vld_d;
            out_sym_q <= out_sym_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign rdy        = used_q < CW'(DEPTH - AF_MARGIN);
    assign aempty     = used_q == CW'(1);
    assign out_vld    = out_vld_q;
    assign out_sym    = out_sym_q;
    assign used_slots = used_q;
    assign hwm        = hwm_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_cr_huf_comp_sq_pf.sv
// tb/tb_cr_huf_comp_sq_pf.sv - scoreboard bench for the show-ahead symbol queue
module tb_cr_huf_comp_sq_pf;
    import cr_huf_compPKG::*;

    localparam int DEPTH = 16;
    localparam int AF    = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SYM_W = $bits(s_sq_sym);

    logic          clk, rst_n, clear, wr, rd;
    s_sq_sym       wr_sym, out_sym;
    logic          rdy, out_vld, aempty, overflow, underflow;
    logic [CW-1:0] used_slots, hwm;

    s_sq_sym sb[$];
    int      m_hwm;
    bit      m_ovf, m_udf;
    int      vectors, miscompares;

    cr_huf_comp_sq_pf #(.DEPTH(DEPTH), .AF_MARGIN(AF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .wr         (wr),
        .wr_sym     (wr_sym),
        .rdy        (rdy),
        .rd         (rd),
        .out_vld    (out_vld),
        .out_sym    (out_sym),
        .used_slots (used_slots),
        .aempty     (aempty),
        .hwm        (hwm),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic s_sq_sym mk(input int v);
        logic [95:0] r;
        s_sq_sym     s;
        r = {$urandom(), $urandom(), $urandom()};
        s = r[SYM_W-1:0];
        s.data = '0;
        s.data[31:0] = v;
        return s;
    endfunction

    // Drives one cycle and advances the reference queue model alongside it.
    task automatic tick(input bit w, input s_sq_sym d, input bit r, input bit c);
        bit p, q;
        wr = w; wr_sym = d; rd = r; clear = c;
        if (c) begin
            sb.delete();
            m_hwm = 0;
        end else begin
            p = r && sb.size() > 0;
            q = w && (sb.size() < DEPTH || p);
            if (r && sb.size() == 0) m_udf = 1'b1;
            if (w && !q) m_ovf = 1'b1;
            if (p) void'(sb.pop_front());
            if (q) sb.push_back(d);
            if (sb.size() > m_hwm) m_hwm = sb.size();
        end
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clear = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_hwm = 0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; wr = 1'b0; rd = 1'b0; clear = 1'b0; wr_sym = '0;
        model_reset();
        #2;
        vectors++;
        if ({out_vld, used_slots, hwm, overflow, underflow, aempty} !== '0 || out_sym !== '0) begin
            miscompares++;
            $display("FAIL reset_zero got vld=%0b used=%0d hwm=%0d ovf=%0b udf=%0b ae=%0b sym=%h exp all 0",
                     out_vld, used_slots, hwm, overflow, underflow, aempty, out_sym);
        end
        vectors++;
        if (rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got=%0b exp=1", rdy); end
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    task automatic test_abc();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, mk(32'hA0 + i), 1'b0, 1'b0);
            vectors++;
            if (used_slots !== CW'(i + 1)) begin
                miscompares++; $display("FAIL abc_used got=%0d exp=%0d", used_slots, i + 1);
            end
            vectors++;
            if (out_vld !== 1'b1 || out_sym !== sb[0] || out_sym.data[31:0] !== 32'hA0) begin
                miscompares++; $display("FAIL abc_head got vld=%0b sym=%h exp vld=1 sym=%h", out_vld, out_sym, sb[0]);
            end
        end
        vectors++;
        if (hwm !== CW'(3)) begin miscompares++; $display("FAIL abc_hwm got=%0d exp=3", hwm); end
        while (sb.size() > 0) begin
            vectors++;
            if (out_vld !== 1'b1 || out_sym !== sb[0]) begin
                miscompares++; $display("FAIL abc_drain got=%h exp=%h", out_sym, sb[0]);
            end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        vectors++;
        if (out_vld !== 1'b0 || used_slots !== '0) begin
            miscompares++; $display("FAIL abc_empty got vld=%0b used=%0d exp 0 0", out_vld, used_slots);
        end
    endtask

    task automatic test_fill_overflow();
        int exp_data;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, mk(i), 1'b0, 1'b0);
            vectors++;
            if (rdy !== (sb.size() < DEPTH - AF)) begin
                miscompares++; $display("FAIL fill_rdy used=%0d got=%0b exp=%0b", sb.size(), rdy, sb.size() < DEPTH - AF);
            end
        end
        tick(1'b1, mk(99), 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b1 || used_slots !== CW'(DEPTH)) begin
            miscompares++; $display("FAIL fill_ovf got ovf=%0b used=%0d exp 1 %0d", overflow, used_slots, DEPTH);
        end
        vectors++;
        if (out_sym.data[31:0] !== 32'd0) begin
            miscompares++; $display("FAIL fill_head got=%0d exp=0", out_sym.data[31:0]);
        end
        tick(1'b1, mk(DEPTH), 1'b1, 1'b0);
        vectors++;
        if (used_slots !== CW'(DEPTH) || out_sym.data[31:0] !== 32'd1) begin
            miscompares++; $display("FAIL full_wr_rd got used=%0d head=%0d exp %0d 1", used_slots, out_sym.data[31:0], DEPTH);
        end
        exp_data = 1;
        while (sb.size() > 0) begin
            vectors++;
            if (out_sym !== sb[0] || out_sym.data[31:0] !== 32'(exp_data)) begin
                miscompares++; $display("FAIL fill_order got=%0d exp=%0d", out_sym.data[31:0], exp_data);
            end
            exp_data++;
            tick(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_pass_through();
        s_sq_sym y;
        tick(1'b1, mk(32'h51), 1'b0, 1'b0);
        y = mk(32'h52);
        tick(1'b1, y, 1'b1, 1'b0);
        vectors++;
        if (out_sym !== y || out_vld !== 1'b1 || aempty !== 1'b1 || used_slots !== CW'(1)) begin
            miscompares++; $display("FAIL pass_through got sym=%h vld=%0b ae=%0b used=%0d exp sym=%h 1 1 1",
                                    out_sym, out_vld, aempty, used_slots, y);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_underflow();
        tick(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (underflow !== 1'b1 || used_slots !== '0 || out_vld !== 1'b0) begin
            miscompares++; $display("FAIL underflow got udf=%0b used=%0d vld=%0b exp 1 0 0", underflow, used_slots, out_vld);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) tick(1'b1, mk(32'hC0 + i), 1'b0, 1'b0);
        vectors++;
        if (used_slots !== CW'(5)) begin miscompares++; $display("FAIL clear_pre used got=%0d exp=5", used_slots); end
        tick(1'b1, mk(32'hCF), 1'b1, 1'b1);
        vectors++;
        if (used_slots !== '0 || hwm !== '0 || out_vld !== 1'b0) begin
            miscompares++; $display("FAIL clear_state got used=%0d hwm=%0d vld=%0b exp 0 0 0", used_slots, hwm, out_vld);
        end
        vectors++;
        if (overflow !== m_ovf || underflow !== m_udf) begin
            miscompares++; $display("FAIL clear_sticky got ovf=%0b udf=%0b exp %0b %0b", overflow, underflow, m_ovf, m_udf);
        end
    endtask

    task automatic test_random_reset();
        s_sq_sym x;
        for (int i = 0; i < 40; i++) begin
            bit w, r;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 2) == 0);
            if (r && sb.size() > 0) begin
                vectors++;
                if (out_sym !== sb[0]) begin
                    miscompares++; $display("FAIL rand_pop cyc=%0d got=%h exp=%h", i, out_sym, sb[0]);
                end
            end
            tick(w, mk(32'h100 + i), r, 1'b0);
            vectors++;
            if (used_slots !== CW'(sb.size()) || out_vld !== (sb.size() > 0) || hwm !== CW'(m_hwm)) begin
                miscompares++; $display("FAIL rand_state cyc=%0d got used=%0d vld=%0b hwm=%0d exp %0d %0b %0d",
                                        i, used_slots, out_vld, hwm, sb.size(), sb.size() > 0, m_hwm);
            end
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({out_vld, used_slots, hwm, overflow, underflow, aempty} !== '0 || out_sym !== '0 || rdy !== 1'b1) begin
            miscompares++; $display("FAIL midreset got vld=%0b used=%0d hwm=%0d ovf=%0b udf=%0b rdy=%0b exp 0 0 0 0 0 1",
                                    out_vld, used_slots, hwm, overflow, underflow, rdy);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        x = mk(32'h7E57);
        tick(1'b1, x, 1'b0, 1'b0);
        vectors++;
        if (out_vld !== 1'b1 || out_sym !== x || used_slots !== CW'(1)) begin
            miscompares++; $display("FAIL post_reset_first got vld=%0b sym=%h used=%0d exp 1 %h 1", out_vld, out_sym, used_slots, x);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_abc();
        test_fill_overflow();
        test_pass_through();
        test_underflow();
        test_clear();
        test_random_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
